// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the core's I/D requesters, the port arbiter and one single-port BRAM.
// Ports: i_* (fetch request/response), d_* (data request/response), mem_* (BRAM command and read data).
// master: core requesters plus the BRAM (drive requests and mem_data_out); slave: the arbiter.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_BITS     = 32,
  parameter int MEM_ADDRESS_BITS = 12
);
  localparam int BE_W = DATA_WIDTH / 8;

  // instruction side
  logic                        i_mem_read;
  logic [ADDRESS_BITS-1:0]     i_mem_address_in;
  logic [DATA_WIDTH-1:0]       i_mem_data_out;
  logic [ADDRESS_BITS-1:0]     i_mem_address_out;
  logic                        i_mem_valid;
  logic                        i_mem_ready;

  // data side
  logic                        d_mem_read;
  logic                        d_mem_write;
  logic [BE_W-1:0]             d_mem_byte_en;
  logic [ADDRESS_BITS-1:0]     d_mem_address_in;
  logic [DATA_WIDTH-1:0]       d_mem_data_in;
  logic [DATA_WIDTH-1:0]       d_mem_data_out;
  logic [ADDRESS_BITS-1:0]     d_mem_address_out;
  logic                        d_mem_valid;
  logic                        d_mem_ready;

  // memory side
  logic                        mem_read;
  logic                        mem_write;
  logic [BE_W-1:0]             mem_byte_en;
  logic [MEM_ADDRESS_BITS-1:0] mem_address;
  logic [DATA_WIDTH-1:0]       mem_data_in;
  logic [DATA_WIDTH-1:0]       mem_data_out;

  modport master (
    output i_mem_read, i_mem_address_in,
    input  i_mem_data_out, i_mem_address_out, i_mem_valid, i_mem_ready,
    output d_mem_read, d_mem_write, d_mem_byte_en, d_mem_address_in, d_mem_data_in,
    input  d_mem_data_out, d_mem_address_out, d_mem_valid, d_mem_ready,
    input  mem_read, mem_write, mem_byte_en, mem_address, mem_data_in,
    output mem_data_out
  );

  modport slave (
    input  i_mem_read, i_mem_address_in,
    output i_mem_data_out, i_mem_address_out, i_mem_valid, i_mem_ready,
    input  d_mem_read, d_mem_write, d_mem_byte_en, d_mem_address_in, d_mem_data_in,
    output d_mem_data_out, d_mem_address_out, d_mem_valid, d_mem_ready,
    output mem_read, mem_write, mem_byte_en, mem_address, mem_data_in,
    input  mem_data_out
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one single-port BRAM between instruction fetch and data access; counts conflicts.
// Latency: accept is combinational (ready same cycle); read response valid exactly 1 cycle after accept.
// Backpressure: loser of a conflict sees ready=0 and must hold its request. Ports: clock, reset (sync, low),
// bus (slave view of mem_port_arbiter_if), conflict_count (saturating count of cycles with both requesting).
module mem_port_arbiter #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_BITS     = 32,
  parameter int MEM_ADDRESS_BITS = 12,
  parameter int COUNT_BITS       = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  mem_port_arbiter_if.slave     bus,
  output logic [COUNT_BITS-1:0] conflict_count
);
  localparam int BE_W = DATA_WIDTH / 8;
  localparam int OFS  = (BE_W > 1) ? $clog2(BE_W) : 0;

  typedef enum logic {SIDE_I = 1'b0, SIDE_D = 1'b1} side_e;

  side_e                   last_grant_q, last_grant_d;
  side_e                   resp_owner_q, resp_owner_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [ADDRESS_BITS-1:0] i_addr_q, i_addr_d;
  logic [ADDRESS_BITS-1:0] d_addr_q, d_addr_d;
  logic [COUNT_BITS-1:0]   count_q, count_d;

  logic i_req, d_req, d_is_write, conflict, grant_i, grant_d;

  always_comb begin
    i_req      = bus.i_mem_read;
    d_req      = bus.d_mem_read | bus.d_mem_write;
    // read+write together is a write
    d_is_write = bus.d_mem_write;
    conflict   = i_req & d_req;
    // On a conflict the side that was not served last wins; nothing is granted while in reset.
    grant_i    = reset & i_req & (~d_req | (last_grant_q == SIDE_D));
    grant_d    = reset & d_req & (~i_req | (last_grant_q == SIDE_I));
  end

  // Memory command follows the granted side combinationally.
  always_comb begin
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_byte_en = '0;
    bus.mem_address = '0;
    bus.mem_data_in = '0;
    if (grant_i) begin
      bus.mem_read    = 1'b1;
      bus.mem_address = bus.i_mem_address_in[OFS +: MEM_ADDRESS_BITS];
    end else if (grant_d) begin
      bus.mem_address = bus.d_mem_address_in[OFS +: MEM_ADDRESS_BITS];
      if (d_is_write) begin
        bus.mem_write   = 1'b1;
        bus.mem_byte_en = bus.d_mem_byte_en;
        bus.mem_data_in = bus.d_mem_data_in;
      end else begin
        bus.mem_read = 1'b1;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    resp_owner_d = resp_owner_q;
    resp_valid_d = 1'b0;
    i_addr_d     = i_addr_q;
    d_addr_d     = d_addr_q;
    count_d      = count_q;
    if (grant_i) begin
      last_grant_d = SIDE_I;
      resp_valid_d = 1'b1;
      resp_owner_d = SIDE_I;
      i_addr_d     = bus.i_mem_address_in;
    end else if (grant_d) begin
      last_grant_d = SIDE_D;
      if (!d_is_write) begin
        resp_valid_d = 1'b1;
        resp_owner_d = SIDE_D;
        d_addr_d     = bus.d_mem_address_in;
      end
    end
    if (conflict && (count_q != {COUNT_BITS{1'b1}})) begin
      count_d = count_q + COUNT_BITS'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      last_grant_q <= SIDE_I;
      resp_owner_q <= SIDE_I;
      resp_valid_q <= 1'b0;
      i_addr_q     <= '0;
      d_addr_q     <= '0;
      count_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      resp_owner_q <= resp_owner_d;
      resp_valid_q <= resp_valid_d;
      i_addr_q     <= i_addr_d;
      d_addr_q     <= d_addr_d;
      count_q      <= count_d;
    end
  end

  assign bus.i_mem_ready       = grant_i;
  assign bus.d_mem_ready       = grant_d;
  // Gating with reset suppresses a response whose accept was followed by reset.
  assign bus.i_mem_valid       = reset & resp_valid_q & (resp_owner_q == SIDE_I);
  assign bus.d_mem_valid       = reset & resp_valid_q & (resp_owner_q == SIDE_D);
  assign bus.i_mem_address_out = i_addr_q;
  assign bus.d_mem_address_out = d_addr_q;
  assign bus.i_mem_data_out    = bus.mem_data_out;
  assign bus.d_mem_data_out    = bus.mem_data_out;
  assign conflict_count        = count_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int DW = 32, AW = 32, MAW = 12;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .MEM_ADDRESS_BITS(MAW)) bus ();
  mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .MEM_ADDRESS_BITS(MAW)) bus4 ();

  logic [15:0] cc;
  logic [3:0]  cc4;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .MEM_ADDRESS_BITS(MAW), .COUNT_BITS(16)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave), .conflict_count(cc));
  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .MEM_ADDRESS_BITS(MAW), .COUNT_BITS(4)) dut4 (
    .clock(clock), .reset(reset), .bus(bus4.slave), .conflict_count(cc4));

  // second instance sees identical stimulus; only its narrow counter is checked
  assign bus4.i_mem_read       = bus.i_mem_read;
  assign bus4.i_mem_address_in = bus.i_mem_address_in;
  assign bus4.d_mem_read       = bus.d_mem_read;
  assign bus4.d_mem_write      = bus.d_mem_write;
  assign bus4.d_mem_byte_en    = bus.d_mem_byte_en;
  assign bus4.d_mem_address_in = bus.d_mem_address_in;
  assign bus4.d_mem_data_in    = bus.d_mem_data_in;

  // single-port BRAM, one-cycle read latency
  logic [DW-1:0] bram [0:4095];
  logic [DW-1:0] rdata;
  always @(posedge clock) begin
    if (bus.mem_write)
      for (int b = 0; b < 4; b++)
        if (bus.mem_byte_en[b]) bram[bus.mem_address][8*b +: 8] <= bus.mem_data_in[8*b +: 8];
    if (bus.mem_read) rdata <= bram[bus.mem_address];
  end
  assign bus.mem_data_out  = rdata;
  assign bus4.mem_data_out = rdata;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit          exp_last;          // 0 = I served last, 1 = D
  int          exp_cc, exp_cc4;
  bit          exp_gi, exp_gd;
  bit          cur_iv, cur_dv;
  logic [31:0] cur_ia, cur_da, cur_idat, cur_ddat;
  logic [31:0] ref_mem [0:4095];

  function automatic void predict();
    bit ir = bus.i_mem_read;
    bit dq = bus.d_mem_read | bus.d_mem_write;
    exp_gi = 0;
    exp_gd = 0;
    if (reset) begin
      if (ir && dq) begin
        if (exp_last) exp_gi = 1; else exp_gd = 1;
      end else begin
        exp_gi = ir;
        exp_gd = dq;
      end
    end
  endfunction

  // advance the model across one rising edge, then step to just after it
  task automatic step_edge();
    bit n_iv, n_dv;
    logic [31:0] n_ia, n_da, n_idat, n_ddat;
    int w;
    predict();
    n_iv = 0; n_dv = 0;
    n_ia = cur_ia; n_da = cur_da; n_idat = cur_idat; n_ddat = cur_ddat;
    if (!reset) begin
      exp_last = 0; exp_cc = 0; exp_cc4 = 0; n_ia = 0; n_da = 0;
    end else begin
      if (bus.i_mem_read && (bus.d_mem_read || bus.d_mem_write)) begin
        if (exp_cc < 65535) exp_cc++;
        if (exp_cc4 < 15) exp_cc4++;
      end
      if (exp_gi) begin
        exp_last = 0;
        n_iv = 1;
        n_ia = bus.i_mem_address_in;
        n_idat = ref_mem[int'(bus.i_mem_address_in[13:2])];
      end
      if (exp_gd) begin
        exp_last = 1;
        w = int'(bus.d_mem_address_in[13:2]);
        if (bus.d_mem_write) begin
          for (int b = 0; b < 4; b++)
            if (bus.d_mem_byte_en[b]) ref_mem[w][8*b +: 8] = bus.d_mem_data_in[8*b +: 8];
        end else begin
          n_dv = 1;
          n_da = bus.d_mem_address_in;
          n_ddat = ref_mem[w];
        end
      end
    end
    @(posedge clock);
    #1;
    cur_iv = n_iv; cur_dv = n_dv; cur_ia = n_ia; cur_da = n_da; cur_idat = n_idat; cur_ddat = n_ddat;
  endtask

  task automatic idle_inputs();
    bus.i_mem_read = 0; bus.i_mem_address_in = '0;
    bus.d_mem_read = 0; bus.d_mem_write = 0; bus.d_mem_byte_en = '0;
    bus.d_mem_address_in = '0; bus.d_mem_data_in = '0;
  endtask

  task automatic test_reset();
    reset = 0;
    bus.i_mem_read = 1; bus.i_mem_address_in = $urandom;
    bus.d_mem_read = 1; bus.d_mem_address_in = $urandom;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++; if (bus.i_mem_ready !== 1'b0) begin errors++; $display("FAIL rst_i_ready cyc=%0d got=%b exp=0", k, bus.i_mem_ready); end
      checks++; if (bus.d_mem_ready !== 1'b0) begin errors++; $display("FAIL rst_d_ready cyc=%0d got=%b exp=0", k, bus.d_mem_ready); end
      checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_cmd cyc=%0d got rd=%b wr=%b exp 0/0", k, bus.mem_read, bus.mem_write); end
      step_edge();
    end
    idle_inputs();
    reset = 1;
    @(negedge clock);
    checks++; if (bus.i_mem_valid !== 1'b0) begin errors++; $display("FAIL idle_i_valid got=%b exp=0", bus.i_mem_valid); end
    checks++; if (bus.d_mem_valid !== 1'b0) begin errors++; $display("FAIL idle_d_valid got=%b exp=0", bus.d_mem_valid); end
    checks++; if (bus.i_mem_address_out !== 32'h0) begin errors++; $display("FAIL idle_i_aout got=%h exp=0", bus.i_mem_address_out); end
    checks++; if (bus.d_mem_address_out !== 32'h0) begin errors++; $display("FAIL idle_d_aout got=%h exp=0", bus.d_mem_address_out); end
    checks++; if (cc !== 16'h0 || cc4 !== 4'h0) begin errors++; $display("FAIL idle_count got=%0d/%0d exp=0/0", cc, cc4); end
    checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL idle_mem_cmd got rd=%b wr=%b exp 0/0", bus.mem_read, bus.mem_write); end
    step_edge();
  endtask

  // fill words 0..15 and 64 through the data port
  task automatic test_write_preload();
    int words [17];
    for (int i = 0; i < 16; i++) words[i] = i;
    words[16] = 64;
    for (int i = 0; i < 17; i++) begin
      bus.d_mem_write = 1; bus.d_mem_byte_en = 4'hF;
      bus.d_mem_address_in = 32'(words[i]) << 2;
      bus.d_mem_data_in = (words[i] == 4) ? 32'hCAFE_0004 : (words[i] == 8) ? 32'h1122_3344 : $urandom;
      @(negedge clock);
      checks++; if (bus.d_mem_ready !== 1'b1) begin errors++; $display("FAIL pre_d_ready w=%0d got=%b exp=1", words[i], bus.d_mem_ready); end
      checks++; if (bus.mem_write !== 1'b1 || bus.mem_address !== 12'(words[i])) begin errors++; $display("FAIL pre_mem_cmd w=%0d got wr=%b addr=%0d", words[i], bus.mem_write, bus.mem_address); end
      checks++; if (bus.d_mem_valid !== 1'b0) begin errors++; $display("FAIL pre_no_valid w=%0d got=%b exp=0", words[i], bus.d_mem_valid); end
      step_edge();
    end
    idle_inputs();
  endtask

  task automatic test_lone_i_read();
    bus.i_mem_read = 1; bus.i_mem_address_in = 32'h0000_0010;
    @(negedge clock);
    checks++; if (bus.i_mem_ready !== 1'b1) begin errors++; $display("FAIL lone_i_ready got=%b exp=1", bus.i_mem_ready); end
    checks++; if (bus.mem_address !== 12'd4 || bus.mem_read !== 1'b1) begin errors++; $display("FAIL lone_mem_cmd got addr=%0d rd=%b exp 4/1", bus.mem_address, bus.mem_read); end
    step_edge();
    idle_inputs();
    @(negedge clock);
    checks++; if (bus.i_mem_valid !== 1'b1) begin errors++; $display("FAIL lone_i_valid got=%b exp=1", bus.i_mem_valid); end
    checks++; if (bus.i_mem_address_out !== 32'h10) begin errors++; $display("FAIL lone_i_aout got=%h exp=10", bus.i_mem_address_out); end
    checks++; if (bus.i_mem_data_out !== 32'hCAFE_0004) begin errors++; $display("FAIL lone_i_data got=%h exp=cafe0004", bus.i_mem_data_out); end
    checks++; if (bus.d_mem_valid !== 1'b0) begin errors++; $display("FAIL lone_d_valid got=%b exp=0", bus.d_mem_valid); end
    step_edge();
  endtask

  task automatic test_conflict();
    bus.i_mem_read = 1; bus.i_mem_address_in = 32'h0;
    bus.d_mem_read = 1; bus.d_mem_address_in = 32'h100;
    for (int k = 0; k <= 8; k++) begin
      if (k == 8) idle_inputs();
      @(negedge clock);
      if (k < 8) begin
        checks++; if (bus.d_mem_ready !== ((k % 2) == 0)) begin errors++; $display("FAIL cfl_d_ready cyc=%0d got=%b exp=%b", k, bus.d_mem_ready, (k % 2) == 0); end
        checks++; if (bus.i_mem_ready !== ((k % 2) == 1)) begin errors++; $display("FAIL cfl_i_ready cyc=%0d got=%b exp=%b", k, bus.i_mem_ready, (k % 2) == 1); end
      end
      checks++; if (cc !== 16'(k)) begin errors++; $display("FAIL cfl_count cyc=%0d got=%0d exp=%0d", k, cc, k); end
      if (k > 0) begin
        checks++; if (bus.d_mem_valid !== (((k - 1) % 2) == 0)) begin errors++; $display("FAIL cfl_d_valid cyc=%0d got=%b", k, bus.d_mem_valid); end
        checks++; if (bus.i_mem_valid !== (((k - 1) % 2) == 1)) begin errors++; $display("FAIL cfl_i_valid cyc=%0d got=%b", k, bus.i_mem_valid); end
        checks++;
        if (bus.d_mem_valid === 1'b1 && bus.d_mem_data_out !== ref_mem[64]) begin errors++; $display("FAIL cfl_d_data cyc=%0d got=%h exp=%h", k, bus.d_mem_data_out, ref_mem[64]); end
        else if (bus.i_mem_valid === 1'b1 && bus.i_mem_data_out !== ref_mem[0]) begin errors++; $display("FAIL cfl_i_data cyc=%0d got=%h exp=%h", k, bus.i_mem_data_out, ref_mem[0]); end
      end
      step_edge();
    end
  endtask

  task automatic test_write_then_read();
    bus.d_mem_write = 1; bus.d_mem_byte_en = 4'b0011;
    bus.d_mem_address_in = 32'h20; bus.d_mem_data_in = 32'hDEAD_BEEF;
    @(negedge clock);
    checks++; if (bus.d_mem_ready !== 1'b1 || bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin errors++; $display("FAIL wr_cmd got rdy=%b wr=%b rd=%b exp 1/1/0", bus.d_mem_ready, bus.mem_write, bus.mem_read); end
    checks++; if (bus.mem_byte_en !== 4'b0011 || bus.mem_data_in !== 32'hDEAD_BEEF || bus.mem_address !== 12'd8) begin errors++; $display("FAIL wr_fields got be=%b dat=%h addr=%0d", bus.mem_byte_en, bus.mem_data_in, bus.mem_address); end
    step_edge();
    bus.d_mem_write = 0; bus.d_mem_read = 1; bus.d_mem_byte_en = '0; bus.d_mem_data_in = '0;
    @(negedge clock);
    checks++; if (bus.d_mem_valid !== 1'b0) begin errors++; $display("FAIL wr_no_valid got=%b exp=0", bus.d_mem_valid); end
    checks++; if (bus.d_mem_ready !== 1'b1 || bus.mem_read !== 1'b1) begin errors++; $display("FAIL rd_cmd got rdy=%b rd=%b exp 1/1", bus.d_mem_ready, bus.mem_read); end
    step_edge();
    idle_inputs();
    @(negedge clock);
    checks++; if (bus.d_mem_valid !== 1'b1) begin errors++; $display("FAIL rd_valid got=%b exp=1", bus.d_mem_valid); end
    checks++; if (bus.d_mem_address_out !== 32'h20) begin errors++; $display("FAIL rd_aout got=%h exp=20", bus.d_mem_address_out); end
    checks++; if (bus.d_mem_data_out !== 32'h1122_BEEF) begin errors++; $display("FAIL rd_data got=%h exp=1122beef", bus.d_mem_data_out); end
    step_edge();
  endtask

  task automatic test_reset_mid_read();
    bus.i_mem_read = 1; bus.i_mem_address_in = 32'h4;
    @(negedge clock);
    checks++; if (bus.i_mem_ready !== 1'b1) begin errors++; $display("FAIL mid_i_ready got=%b exp=1", bus.i_mem_ready); end
    step_edge();
    idle_inputs();
    reset = 0;
    @(negedge clock);
    checks++; if (bus.i_mem_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_in_reset got=%b exp=0", bus.i_mem_valid); end
    step_edge();
    reset = 1;
    @(negedge clock);
    checks++; if (bus.i_mem_valid !== 1'b0 || bus.d_mem_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_after got i=%b d=%b exp 0/0", bus.i_mem_valid, bus.d_mem_valid); end
    checks++; if (bus.i_mem_address_out !== 32'h0) begin errors++; $display("FAIL mid_i_aout got=%h exp=0", bus.i_mem_address_out); end
    step_edge();
  endtask

  task automatic test_saturation();
    // leave last_grant at D, so only a proper reset makes D win the next conflict
    bus.d_mem_write = 1; bus.d_mem_byte_en = 4'hF; bus.d_mem_address_in = 32'h3C; bus.d_mem_data_in = $urandom;
    @(negedge clock);
    step_edge();
    idle_inputs();
    reset = 0;
    @(negedge clock); step_edge();
    @(negedge clock); step_edge();
    reset = 1;
    bus.i_mem_read = 1; bus.i_mem_address_in = 32'h0;
    bus.d_mem_read = 1; bus.d_mem_address_in = 32'h100;
    for (int k = 0; k <= 20; k++) begin
      if (k == 20) idle_inputs();
      @(negedge clock);
      if (k == 0) begin
        checks++; if (bus.d_mem_ready !== 1'b1 || bus.i_mem_ready !== 1'b0) begin errors++; $display("FAIL sat_first_grant got d=%b i=%b exp 1/0", bus.d_mem_ready, bus.i_mem_ready); end
      end
      checks++; if (cc4 !== 4'((k < 15) ? k : 15)) begin errors++; $display("FAIL sat_cc4 cyc=%0d got=%0d exp=%0d", k, cc4, (k < 15) ? k : 15); end
      if (k == 20) begin
        checks++; if (cc !== 16'd20) begin errors++; $display("FAIL sat_cc16 got=%0d exp=20", cc); end
      end
      step_edge();
    end
  endtask

  task automatic test_random();
    bit ip = 0, dp = 0;
    int op;
    logic [11:0] exp_addr;
    for (int k = 0; k < 400; k++) begin
      if (!ip) begin
        bus.i_mem_read = ($urandom_range(0, 9) < 6);
        bus.i_mem_address_in = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      end
      if (!dp) begin
        op = $urandom_range(0, 3);
        bus.d_mem_read = (op == 1) || (op == 3);
        bus.d_mem_write = (op >= 2);
        bus.d_mem_byte_en = 4'($urandom_range(0, 15));
        bus.d_mem_address_in = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        bus.d_mem_data_in = $urandom;
      end
      @(negedge clock);
      predict();
      checks++; if (bus.i_mem_ready !== exp_gi) begin errors++; $display("FAIL rnd_i_ready cyc=%0d got=%b exp=%b", k, bus.i_mem_ready, exp_gi); end
      checks++; if (bus.d_mem_ready !== exp_gd) begin errors++; $display("FAIL rnd_d_ready cyc=%0d got=%b exp=%b", k, bus.d_mem_ready, exp_gd); end
      checks++; if (bus.i_mem_valid !== cur_iv || bus.d_mem_valid !== cur_dv) begin errors++; $display("FAIL rnd_valid cyc=%0d got i=%b d=%b exp i=%b d=%b", k, bus.i_mem_valid, bus.d_mem_valid, cur_iv, cur_dv); end
      checks++; if (bus.i_mem_address_out !== cur_ia || bus.d_mem_address_out !== cur_da) begin errors++; $display("FAIL rnd_aout cyc=%0d got i=%h d=%h exp i=%h d=%h", k, bus.i_mem_address_out, bus.d_mem_address_out, cur_ia, cur_da); end
      if (cur_iv) begin
        checks++; if (bus.i_mem_data_out !== cur_idat) begin errors++; $display("FAIL rnd_i_data cyc=%0d got=%h exp=%h", k, bus.i_mem_data_out, cur_idat); end
      end
      if (cur_dv) begin
        checks++; if (bus.d_mem_data_out !== cur_ddat) begin errors++; $display("FAIL rnd_d_data cyc=%0d got=%h exp=%h", k, bus.d_mem_data_out, cur_ddat); end
      end
      checks++; if (bus.mem_write !== (exp_gd && bus.d_mem_write) || bus.mem_read !== (exp_gi || (exp_gd && !bus.d_mem_write))) begin errors++; $display("FAIL rnd_mem_cmd cyc=%0d got rd=%b wr=%b", k, bus.mem_read, bus.mem_write); end
      if (exp_gi || exp_gd) begin
        exp_addr = exp_gi ? bus.i_mem_address_in[13:2] : bus.d_mem_address_in[13:2];
        checks++; if (bus.mem_address !== exp_addr) begin errors++; $display("FAIL rnd_mem_addr cyc=%0d got=%0d exp=%0d", k, bus.mem_address, exp_addr); end
      end
      checks++; if (cc !== 16'(exp_cc)) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", k, cc, exp_cc); end
      step_edge();
      ip = bus.i_mem_read && !exp_gi;
      dp = (bus.d_mem_read || bus.d_mem_write) && !exp_gd;
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    cur_iv = 0; cur_dv = 0; cur_ia = 0; cur_da = 0; cur_idat = 0; cur_ddat = 0;
    exp_last = 0; exp_cc = 0; exp_cc4 = 0;
    test_reset();
    test_write_preload();
    test_lone_i_read();
    test_conflict();
    test_write_then_read();
    test_reset_mid_read();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port word-addressed BRAM between the instruction-fetch and data-memory requesters of a core.
- Presents the same per-side request/response interface as the dual-port memory subsystem, so the core is unchanged.
- Performs round-robin arbitration on conflicts, tracks the one-cycle read latency, and routes each read response to its owner.
- Counts arbitration conflicts for performance monitoring.

Parameters:
- DATA_WIDTH, 32, data word width; must be a multiple of 8.
- ADDRESS_BITS, 32, byte-address width on the core side.
- MEM_ADDRESS_BITS, 12, word-address width on the memory side.
- COUNT_BITS, 16, width of the conflict counter.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset (sampled on the clock edge; 0 = reset).
- i_mem_read  in  1  instruction read request.
- i_mem_address_in  in  ADDRESS_BITS  instruction byte address.
- i_mem_data_out  out  DATA_WIDTH  instruction read data.
- i_mem_address_out  out  ADDRESS_BITS  address of the returned instruction.
- i_mem_valid  out  1  instruction response valid.
- i_mem_ready  out  1  instruction request accepted this cycle.
- d_mem_read  in  1  data read request.
- d_mem_write  in  1  data write request.
- d_mem_byte_en  in  DATA_WIDTH/8  write byte enables.
- d_mem_address_in  in  ADDRESS_BITS  data byte address.
- d_mem_data_in  in  DATA_WIDTH  write data.
- d_mem_data_out  out  DATA_WIDTH  data read data.
- d_mem_address_out  out  ADDRESS_BITS  address of the returned data.
- d_mem_valid  out  1  data read response valid.
- d_mem_ready  out  1  data request accepted this cycle.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_byte_en  out  DATA_WIDTH/8  memory byte enables.
- mem_address  out  MEM_ADDRESS_BITS  memory word address = address_in[log2(DATA_WIDTH/8) +: MEM_ADDRESS_BITS].
- mem_data_in  out  DATA_WIDTH  memory write data.
- mem_data_out  in  DATA_WIDTH  memory read data, valid one cycle after mem_read.
- conflict_count  out  COUNT_BITS  number of cycles in which both sides requested.

Behaviour:
- Request and accept:
  - d_req = d_mem_read | d_mem_write; i_req = i_mem_read.
  - A request is accepted in any cycle where its ready is 1.
  - A requester holds its request and address stable until accepted.
- Ready (combinational from the requests and last_grant):
  - Only one side requests: that side gets ready = 1.
  - Both request: the side not granted last (last_grant register) wins; the loser's ready = 0.
  - Neither requests: both readies 0, no memory access.
  - While reset = 0: both readies 0, mem_read = 0, mem_write = 0.
- last_grant:
  - Updates only on accepted requests.
  - Reset value is I, so D wins the first conflict after reset.
- Memory drive: mem_* signals are driven combinationally from the granted side.
  - I grant: mem_read = 1, mem_write = 0, mem_byte_en = 0, mem_data_in = 0.
  - D grant with write: mem_write = 1, byte_en and data passed through, mem_read = 0.
  - d_mem_read and d_mem_write both 1: treated as a write. No response is produced.
- Response pipeline (registered): resp_owner, resp_valid and resp_addr capture the accepted read.
  - Next cycle, the owner's *_valid = 1 and its *_address_out = the captured byte address.
  - The other side's valid = 0.
  - Read latency is exactly 1 cycle from acceptance; the ports are fully pipelined, so back-to-back accepts give back-to-back valids.
- Data routing:
  - i_mem_data_out and d_mem_data_out both carry mem_data_out combinationally.
  - Data is meaningful only when the matching valid is 1.
- Writes produce no valid pulse.
- conflict_count:
  - Increments in each non-reset cycle with i_req & d_req.
  - Saturates at all-ones; it does not wrap.
- Reset values: i_mem_valid = 0, d_mem_valid = 0, both *_address_out = 0, conflict_count = 0, last_grant = I.
- Reset asserted mid-operation:
  - A read accepted in the cycle before reset produces no valid; valids are 0 in the cycle after reset is sampled.
  - Any pending requester must re-present after reset is released.

Test Plan:
- Reset then idle: reset = 0 for 3 cycles, then 1 with no requests -> all valids 0, address_outs 0, conflict_count 0, mem_read = mem_write = 0.
- Lone I read: i_mem_read = 1, address 0x0000_0010 -> i_mem_ready = 1 same cycle, mem_address = 4; next cycle i_mem_valid = 1, i_mem_address_out = 0x10, data = the memory word at 4.
- Conflict round-robin: both read continuously from cycle 0 (I at 0x0, D at 0x100) -> grants D, I, D, I…; each side's valid follows its grant by one cycle; conflict_count increments once per conflict cycle.
- D write then read: write 0xDEADBEEF, byte_en 4'b0011, to 0x20, then read 0x20 (memory pre-loaded 0x11223344) -> no valid on the write cycle; read returns 0x1122BEEF with d_mem_valid = 1 and d_mem_address_out = 0x20.
- Reset mid-read: I read accepted at cycle N, reset = 0 sampled at N+1 -> i_mem_valid = 0 after reset, last_grant = I.
- Saturation: COUNT_BITS = 4, both request for 20 cycles -> conflict_count reaches 15 and holds.
